// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction fetch and data access,
// with data priority, a fetch starvation override and an in-order return tag pipeline.
module mem_port_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    logic [CNT_W-1:0]       r_starve_cnt;
    logic [RAM_LATENCY-1:0] r_valid;
    logic [RAM_LATENCY-1:0] r_owner;
    logic                   w_force_inst;
    logic                   w_grant_inst;
    logic                   w_grant_data;

    assign w_force_inst = (STARVE_LIMIT != 0) && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_inst = inst_req && (!data_req || w_force_inst);
    assign w_grant_data = data_req && !w_grant_inst;

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign ram_en       = w_grant_inst || w_grant_data;
    assign ram_addr     = w_grant_data ? data_addr : inst_addr;
    assign ram_wdata    = w_grant_data ? data_wdata : 32'h0;
    assign ram_we       = (w_grant_data && data_wr) ? data_wstrb : 4'b0;

    // Owner bit: 1 = data, 0 = fetch; writes complete through the same path as reads.
    assign inst_data_ok = r_valid[RAM_LATENCY-1] && !r_owner[RAM_LATENCY-1];
    assign data_data_ok = r_valid[RAM_LATENCY-1] && r_owner[RAM_LATENCY-1];
    assign inst_rdata   = ram_rdata;
    assign data_rdata   = ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_valid      <= '0;
            r_owner      <= '0;
        end else begin
            if (w_grant_inst || !inst_req)
                r_starve_cnt <= '0;
            else if (w_grant_data && r_starve_cnt != CNT_W'(STARVE_LIMIT))
                r_starve_cnt <= r_starve_cnt + 1'b1;
            r_valid[0] <= ram_en;
            r_owner[0] <= w_grant_data;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_owner[i] <= r_owner[i-1];
            end
        end
    end
endmodule
